// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stall/flush controller: state encoding,
// the per-cycle control bundle and a few decode-side opcode helpers.
package pipeline_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;
  localparam logic [1:0] ST_HALTED   = 2'd3;

  localparam logic [3:0] REG_ZERO = 4'd0;

  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Bit order matches the register write-enable / bubble-injection ports
  typedef struct packed {
    logic pc_en;
    logic fd_en;
    logic de_en;
    logic xm_en;
    logic mw_en;
    logic fd_flush;
    logic de_flush;
    logic mw_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_ADVANCE  = 8'b11111_000;
  localparam ctrl_t CTRL_MEM_WAIT = 8'b00001_001;
  localparam ctrl_t CTRL_FROZEN   = 8'b00000_000;

  function automatic logic is_load_op(input logic [3:0] op);
    return op == OP_LW;
  endfunction

  function automatic logic is_hlt_op(input logic [3:0] op);
    return op == OP_HLT;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: a load in execute whose destination is read by
// the instruction currently in decode. Register 0 is hardwired and never hazards.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [3:0] rs_fd,
  input  logic [3:0] rt_fd,
  input  logic       uses_rs_fd,
  input  logic       uses_rt_fd,
  input  logic       mem_read_de,
  input  logic [3:0] write_reg_de,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit   = uses_rs_fd && (rs_fd == write_reg_de);
  assign rt_hit   = uses_rt_fd && (rt_fd == write_reg_de);
  assign load_use = mem_read_de && (write_reg_de != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_control.sv
// Central stall/flush controller: decides each cycle which pipeline registers
// advance, hold or take a bubble, and sequences the HLT drain.
module pipeline_control
  import pipeline_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             rs_fd,
  input  logic [3:0]             rt_fd,
  input  logic                   uses_rs_fd,
  input  logic                   uses_rt_fd,
  input  logic                   mem_read_de,
  input  logic [3:0]             write_reg_de,
  input  logic                   branch_taken_fd,
  input  logic                   hlt_fd,
  input  logic                   hlt_mw,
  input  logic                   mem_req_xm,
  input  logic                   mem_ready,
  output logic                   pc_en,
  output logic                   fd_en,
  output logic                   de_en,
  output logic                   xm_en,
  output logic                   mw_en,
  output logic                   fd_flush,
  output logic                   de_flush,
  output logic                   mw_flush,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [1:0]             mode;
  logic                   ret_drain;
  logic                   ret_drain_nxt;
  logic                   load_use;
  logic                   mem_wait;
  logic [STALL_CNT_W-1:0] stall_cnt;
  ctrl_t                  ctrl;

  hazard_detect u_hazard (
    .rs_fd        (rs_fd),
    .rt_fd        (rt_fd),
    .uses_rs_fd   (uses_rs_fd),
    .uses_rt_fd   (uses_rt_fd),
    .mem_read_de  (mem_read_de),
    .write_reg_de (write_reg_de),
    .load_use     (load_use)
  );

  // A memory stall is serviced from RUN or DRAIN, so on release the cycle is
  // handled by the rules of the state it interrupted; that keeps a pending
  // load-use or HLT in decode from slipping through on the release cycle.
  always_comb begin
    mode     = state;
    mem_wait = 1'b0;
    if (state == ST_MEM_WAIT) begin
      mode     = ret_drain ? ST_DRAIN : ST_RUN;
      mem_wait = !mem_ready;
    end else if (state != ST_HALTED) begin
      mem_wait = mem_req_xm && !mem_ready;
    end
  end

  always_comb begin
    ctrl          = CTRL_ADVANCE;
    state_nxt     = mode;
    ret_drain_nxt = 1'b0;
    if (state == ST_HALTED) begin
      ctrl = CTRL_FROZEN;
    end else if (mem_wait) begin
      ctrl          = CTRL_MEM_WAIT;
      state_nxt     = ST_MEM_WAIT;
      ret_drain_nxt = (mode == ST_DRAIN);
    end else if (mode == ST_DRAIN) begin
      ctrl.pc_en    = 1'b0;
      ctrl.fd_flush = 1'b1;
      if (hlt_mw) begin
        state_nxt = ST_HALTED;
      end
    end else if (load_use) begin
      // A taken branch in the same cycle is dropped; decode re-resolves it on retry
      ctrl.pc_en    = 1'b0;
      ctrl.fd_en    = 1'b0;
      ctrl.de_flush = 1'b1;
    end else begin
      ctrl.fd_flush = branch_taken_fd;
      if (hlt_fd) begin
        ctrl.pc_en = 1'b0;
        state_nxt  = ST_DRAIN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      ret_drain <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      ret_drain <= ret_drain_nxt;
      if (mem_wait && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign fd_en        = ctrl.fd_en;
  assign de_en        = ctrl.de_en;
  assign xm_en        = ctrl.xm_en;
  assign mw_en        = ctrl.mw_en;
  assign fd_flush     = ctrl.fd_flush;
  assign de_flush     = ctrl.de_flush;
  assign mw_flush     = ctrl.mw_flush;
  assign halted       = (state == ST_HALTED);
  assign stall_cycles = stall_cnt;

endmodule
